// File: rtl/fpga_ram_nr2w_if.sv
// Bus bundle for the multi-read / multi-write LVT RAM.
interface fpga_ram_nr2w_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned RPORTS = 7,
  parameter int unsigned WPORTS = 2
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [RPORTS-1:0][AW-1:0]    raddr;
  logic [RPORTS-1:0][WIDTH-1:0] rdata;
  logic [WPORTS-1:0][AW-1:0]    waddr;
  logic [WPORTS-1:0][WIDTH-1:0] wdata;
  logic [WPORTS-1:0]            we;
  logic                         init_busy;

  modport master (output raddr, waddr, wdata, we, input rdata, init_busy);
  modport slave  (input raddr, waddr, wdata, we, output rdata, init_busy);
endinterface

// File: rtl/fpga_ram_nr2w.sv
// Multi-read, one/two-write RAM built from one bank per write port plus a
// live-value table that remembers which bank holds the newest copy of each
// entry. A power-up/reset sweep zeroes every entry before writes are taken.
module fpga_ram_nr2w #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned RPORTS  = 7,
  parameter int unsigned WPORTS  = 2,
  parameter int unsigned REG_OUT = 0,
  parameter int unsigned BYPASS  = 1
) (
  input logic             clk,
  input logic             rst,
  fpga_ram_nr2w_if.slave  bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = (WPORTS > 1) ? $clog2(WPORTS) : 1;

  typedef enum logic {INIT, READY} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          init_act;

  logic [WPORTS-1:0]            bank_we;
  logic [WPORTS-1:0][AW-1:0]    bank_waddr;
  logic [WPORTS-1:0][WIDTH-1:0] bank_wdata;
  logic [WIDTH-1:0]             bank_q [WPORTS][DEPTH];

  logic [RPORTS-1:0][WIDTH-1:0] mem_rd;
  logic [RPORTS-1:0][WIDTH-1:0] rd_val;

  // State register: reset restarts the clear sweep from entry 0
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: sweep one entry per cycle, then stay READY until reset
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == AW'(DEPTH - 1)) state_d = READY;
      end
      READY:   state_d = READY;
      default: state_d = INIT;
    endcase
  end

  // FSM outputs: busy flag and per-bank write controls (sweep overrides user writes)
  always_comb begin
    init_act = (state_q == INIT);
    for (int unsigned p = 0; p < WPORTS; p++) begin
      if (init_act) begin
        bank_we[p]    = 1'b1;
        bank_waddr[p] = cnt_q;
        bank_wdata[p] = '0;
      end else begin
        bank_we[p]    = bus.we[p];
        bank_waddr[p] = bus.waddr[p];
        bank_wdata[p] = bus.wdata[p];
      end
    end
  end

  assign bus.init_busy = init_act;

  // Bank storage: each write port owns one bank
  always_ff @(posedge clk) begin
    for (int unsigned p = 0; p < WPORTS; p++) begin
      if (bank_we[p]) bank_q[p][bank_waddr[p]] <= bank_wdata[p];
    end
  end

  generate
    if (WPORTS > 1) begin : g_lvt
      logic [LW-1:0] lvt_q [DEPTH];

      // LVT update: ascending port order lets port 1 win an address collision
      always_ff @(posedge clk) begin
        for (int unsigned p = 0; p < WPORTS; p++) begin
          if (bank_we[p]) lvt_q[bank_waddr[p]] <= init_act ? '0 : LW'(p);
        end
      end

      // Bank read steered by the LVT entry of each read address
      always_comb begin
        for (int unsigned r = 0; r < RPORTS; r++) begin
          mem_rd[r] = bank_q[lvt_q[bus.raddr[r]]][bus.raddr[r]];
        end
      end
    end else begin : g_single
      // Single write port: bank 0 is always the live copy
      always_comb begin
        for (int unsigned r = 0; r < RPORTS; r++) begin
          mem_rd[r] = bank_q[0][bus.raddr[r]];
        end
      end
    end
  endgenerate

  // Read value: optional same-cycle write forwarding, forced to zero while sweeping
  always_comb begin
    for (int unsigned r = 0; r < RPORTS; r++) begin
      rd_val[r] = mem_rd[r];
      if (BYPASS != 0) begin
        for (int unsigned p = 0; p < WPORTS; p++) begin
          if (bus.we[p] && (bus.waddr[p] == bus.raddr[r])) rd_val[r] = bus.wdata[p];
        end
      end
      if (init_act) rd_val[r] = '0;
    end
  end

  generate
    if (REG_OUT != 0) begin : g_reg_out
      logic [RPORTS-1:0][WIDTH-1:0] rdata_q, rdata_d;

      // Registered read path input
      always_comb begin
        rdata_d = rd_val;
      end

      // Read output register, cleared by reset
      always_ff @(posedge clk) begin
        if (rst) rdata_q <= '0;
        else     rdata_q <= rdata_d;
      end

      assign bus.rdata = rdata_q;
    end else begin : g_comb_out
      assign bus.rdata = rd_val;
    end
  endgenerate
endmodule

// File: tb/tb_fpga_ram_nr2w.sv
// Bench for fpga_ram_nr2w: three instances (forwarding comb, no-forwarding
// comb, forwarding registered) share one stimulus stream and are checked
// against a flat memory model of the visible behaviour.
module tb_fpga_ram_nr2w;
  localparam int W  = 32;
  localparam int D  = 64;
  localparam int RP = 7;
  localparam int WP = 2;
  localparam int AW = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [RP-1:0][AW-1:0] raddr_v;
  logic [WP-1:0][AW-1:0] waddr_v;
  logic [WP-1:0][W-1:0]  wdata_v;
  logic [WP-1:0]         we_v;

  fpga_ram_nr2w_if #(.WIDTH(W), .DEPTH(D), .RPORTS(RP), .WPORTS(WP)) if0 ();
  fpga_ram_nr2w_if #(.WIDTH(W), .DEPTH(D), .RPORTS(RP), .WPORTS(WP)) if1 ();
  fpga_ram_nr2w_if #(.WIDTH(W), .DEPTH(D), .RPORTS(RP), .WPORTS(WP)) if2 ();

  assign if0.raddr = raddr_v; assign if0.waddr = waddr_v;
  assign if0.wdata = wdata_v; assign if0.we    = we_v;
  assign if1.raddr = raddr_v; assign if1.waddr = waddr_v;
  assign if1.wdata = wdata_v; assign if1.we    = we_v;
  assign if2.raddr = raddr_v; assign if2.waddr = waddr_v;
  assign if2.wdata = wdata_v; assign if2.we    = we_v;

  fpga_ram_nr2w #(.WIDTH(W), .DEPTH(D), .RPORTS(RP), .WPORTS(WP),
                  .REG_OUT(0), .BYPASS(1)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  fpga_ram_nr2w #(.WIDTH(W), .DEPTH(D), .RPORTS(RP), .WPORTS(WP),
                  .REG_OUT(0), .BYPASS(0)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  fpga_ram_nr2w #(.WIDTH(W), .DEPTH(D), .RPORTS(RP), .WPORTS(WP),
                  .REG_OUT(1), .BYPASS(1)) dut2 (.clk(clk), .rst(rst), .bus(if2));

  // Reference model: visible contents, cycles of sweep left, registered view
  logic [W-1:0] mem_m [D];
  int           init_left;
  logic [W-1:0] prev_reg [RP];
  int           n_assert;
  int           n_fail;
  bit           chk_en;

  task automatic check(string tag, logic [W-1:0] obs, logic [W-1:0] expv);
    n_assert++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [W-1:0] ref_read(int a, bit byp);
    logic [W-1:0] v;
    if (init_left > 0) return '0;
    v = mem_m[a];
    if (byp) begin
      for (int p = 0; p < WP; p++)
        if (we_v[p] && int'(waddr_v[p]) == a) v = wdata_v[p];
    end
    return v;
  endfunction

  task automatic rand_inputs();
    for (int r = 0; r < RP; r++) raddr_v[r] = AW'($urandom_range(D - 1));
    for (int p = 0; p < WP; p++) begin
      waddr_v[p] = AW'($urandom_range(D - 1));
      wdata_v[p] = $urandom;
    end
    we_v = WP'($urandom_range(3));
  endtask

  task automatic set_reads(int a);
    for (int r = 0; r < RP; r++) raddr_v[r] = AW'(a);
  endtask

  // One clock cycle: check all outputs mid-cycle, then advance the model at the edge
  task automatic tick();
    logic [W-1:0] e0 [RP];
    @(negedge clk);
    for (int r = 0; r < RP; r++) e0[r] = ref_read(int'(raddr_v[r]), 1'b1);
    if (chk_en) begin
      check("busy_d0", W'(if0.init_busy), W'(init_left > 0));
      check("busy_d2", W'(if2.init_busy), W'(init_left > 0));
      for (int r = 0; r < RP; r++) begin
        check($sformatf("byp_comb[%0d]", r), if0.rdata[r], e0[r]);
        check($sformatf("nobyp_comb[%0d]", r), if1.rdata[r], ref_read(int'(raddr_v[r]), 1'b0));
        check($sformatf("byp_reg[%0d]", r), if2.rdata[r], prev_reg[r]);
      end
    end
    @(posedge clk);
    for (int r = 0; r < RP; r++) prev_reg[r] = rst ? '0 : e0[r];
    if (rst) begin
      init_left = D;
      for (int a = 0; a < D; a++) mem_m[a] = '0;
    end else if (init_left > 0) begin
      init_left--;
    end else begin
      for (int p = 0; p < WP; p++) if (we_v[p]) mem_m[waddr_v[p]] = wdata_v[p];
    end
    #1;
  endtask

  // Runs the sweep with random traffic and checks its length
  task automatic sweep_len(string tag);
    int cnt;
    cnt = 0;
    while (if0.init_busy && cnt < 200) begin
      rand_inputs();
      tick();
      cnt++;
    end
    check(tag, W'(cnt), W'(D));
  endtask

  initial begin
    #2000000;
    n_fail++;
    $error("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_assert = 0; n_fail = 0; chk_en = 0; init_left = 0;
    for (int a = 0; a < D; a++) mem_m[a] = '0;
    for (int r = 0; r < RP; r++) prev_reg[r] = '0;
    rand_inputs();

    // Reset pulse and full sweep with writes attempted throughout
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_en = 1;
    sweep_len("sweep_len_first");

    // Port 0 write then broadcast read of the same entry
    we_v = 2'b01; waddr_v[0] = 6'd5; wdata_v[0] = 32'hDEADBEEF; set_reads(12);
    tick();
    we_v = 2'b00; set_reads(5);
    #1 check("s_addr5_all", if0.rdata[RP-1], 32'hDEADBEEF);
    tick();

    // Same-address collision: port 1 wins, then port 0 overwrites
    we_v = 2'b11; waddr_v[0] = 6'd9; waddr_v[1] = 6'd9;
    wdata_v[0] = 32'h1111; wdata_v[1] = 32'h2222; set_reads(20);
    tick();
    we_v = 2'b00; set_reads(9);
    #1 check("s_collide", if0.rdata[0], 32'h2222);
    tick();
    we_v = 2'b01; wdata_v[0] = 32'h3333; set_reads(21);
    tick();
    we_v = 2'b00; set_reads(9);
    #1 check("s_overwrite", if0.rdata[3], 32'h3333);
    tick();

    // Read-during-write with and without forwarding
    we_v = 2'b01; waddr_v[0] = 6'd3; wdata_v[0] = 32'hA5A5; set_reads(3);
    #1 check("s_bypass_on", if0.rdata[0], 32'hA5A5);
    check("s_bypass_off", if1.rdata[0], 32'h0);
    tick();
    we_v = 2'b00;
    #1 check("s_bypass_off_next", if1.rdata[0], 32'hA5A5);
    tick();

    // Registered output latency on an address change
    we_v = 2'b01; waddr_v[0] = 6'd7; wdata_v[0] = 32'h55; set_reads(8);
    tick();
    we_v = 2'b00; set_reads(7);
    #1 check("s_regout_before", if2.rdata[0], 32'h0);
    tick();
    check("s_regout_after", if2.rdata[0], 32'h55);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      rand_inputs();
      tick();
    end

    // Fill every entry with a distinct value
    for (int i = 0; i < D / 2; i++) begin
      rand_inputs();
      we_v = 2'b11;
      waddr_v[0] = AW'(2 * i);     wdata_v[0] = 32'hC000_0000 + 32'(2 * i);
      waddr_v[1] = AW'(2 * i + 1); wdata_v[1] = 32'hC000_0000 + 32'(2 * i + 1);
      tick();
    end
    we_v = 2'b00; set_reads(33);
    #1 check("s_fill_33", if0.rdata[0], 32'hC000_0021);
    tick();

    // Reset, abort the sweep at count 20 with a second reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      rand_inputs();
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sweep_len("sweep_len_restart");

    // Every entry reads zero on every port after the sweep
    we_v = 2'b00;
    for (int c = 0; c < (D + RP - 1) / RP; c++) begin
      for (int r = 0; r < RP; r++) raddr_v[r] = AW'((c * RP + r) % D);
      tick();
    end
    set_reads(33);
    #1 check("s_cleared_33", if0.rdata[5], 32'h0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/fpga_ram_nr2w.md
FPGA_RAM_NR2W -- requirements
Module: fpga_ram_nr2w

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the data bits per entry.
REQ-002 The block SHALL have parameter DEPTH, default 64, giving the entry count; legal values are powers of two from 2 to 256.
REQ-003 The block SHALL have parameter RPORTS, default 7, giving the read port count; legal range is 1 to 8.
REQ-004 The block SHALL have parameter WPORTS, default 2, giving the write port count; legal values are 1 and 2.
REQ-005 The block SHALL have parameter REG_OUT, default 0: 0 selects an asynchronous read, 1 selects a read registered by one cycle.
REQ-006 The block SHALL have parameter BYPASS, default 1: 1 enables write-to-read forwarding, 0 disables it.
REQ-007 The block SHALL have port clk, input, 1 bit: the single clock, with all state on the rising edge.
REQ-008 The block SHALL have port rst, input, 1 bit: the reset, synchronous and active-high.
REQ-009 The block SHALL have port raddr, input, RPORTS x AW bits, where AW=$clog2(DEPTH): one read address per read port.
REQ-010 The block SHALL have port rdata, output, RPORTS x WIDTH bits: one read data word per read port.
REQ-011 The block SHALL have port waddr, input, WPORTS x AW bits: one write address per write port.
REQ-012 The block SHALL have port wdata, input, WPORTS x WIDTH bits: one write data word per write port.
REQ-013 The block SHALL have port we, input, WPORTS bits: the per-port write enable.
REQ-014 The block SHALL have port init_busy, output, 1 bit: high while the clear sweep runs.

Function
REQ-015 Storage SHALL use the live-value-table scheme.
- One RPORTS-read, 1-write bank exists per write port.
- An LVT of DEPTH x max(1,$clog2(WPORTS)) bits records the last writer of each entry.
- Read data is taken from the bank that the LVT selects.
REQ-016 The control FSM SHALL have the states INIT and READY.
- rst forces INIT with sweep counter = 0.
- INIT advances the counter by 1 per cycle.
- INIT moves to READY on the cycle after the counter reaches DEPTH-1.
- READY is held until rst.
REQ-017 In INIT, every cycle SHALL write zero to entry[counter] in all banks and set LVT[counter]=0.
REQ-018 In INIT, writes on we SHALL be ignored.
REQ-019 In INIT, rdata SHALL be forced to 0.
REQ-020 init_busy SHALL equal 1 exactly in INIT.
- After rst deasserts, init_busy stays high for DEPTH cycles.
- The first accepted write occurs in cycle DEPTH, counting the first cycle after rst as cycle 0.
REQ-021 In READY, write port p with we[p]=1 SHALL update bank p entry waddr[p] and LVT[waddr[p]]=p at the next rising edge.
REQ-022 A simultaneous write of the same address from both ports SHALL leave the port 1 data as the stored value.
REQ-023 With REG_OUT=0, rdata[r] SHALL be a combinational function of raddr[r] and the stored state, with zero-cycle latency.
REQ-024 With REG_OUT=1, rdata[r] SHALL present the value addressed at the previous edge, with one-cycle latency.
REQ-025 With BYPASS=1, a read whose address matches an enabled write in the same cycle SHALL return that cycle's wdata.
- When both write ports match, port 1 wins.
- With REG_OUT=0 this is a combinational path.
- With REG_OUT=1 the forwarded value is captured into the read register.
REQ-026 With BYPASS=0, a same-cycle read-during-write SHALL return the pre-write contents.
REQ-027 Read ports SHALL be fully independent.
- Any addresses may be read on any ports in the same cycle, including duplicates.
- Duplicate addresses return identical data.
REQ-028 Out-of-range addresses SHALL NOT exist, because AW exactly spans DEPTH.
REQ-029 With WPORTS=1, the LVT SHALL be omitted and bank 0 read directly, with identical visible behaviour.

Reset
REQ-030 rst asserted in any cycle SHALL restart INIT at counter 0 on the next edge, including rst asserted mid-sweep.
REQ-031 The read output register for REG_OUT=1 SHALL reset to 0.
REQ-032 After a completed sweep, every entry SHALL read 0 on every port.
REQ-033 No entry contents SHALL survive reset.

Verification
REQ-034 Scenario: default parameters; pulse rst for 1 cycle -> init_busy=1 for exactly 64 cycles; rdata=0 on all ports during INIT; we=1 during INIT has no effect.
REQ-035 Scenario: READY; write port 0 addr 5 = 0xDEADBEEF; next cycle all 7 ports read addr 5 -> all return 0xDEADBEEF (REG_OUT=0).
REQ-036 Scenario: same cycle, port 0 writes addr 9 = 0x1111 and port 1 writes addr 9 = 0x2222 -> subsequent read = 0x2222; a following port 0 write of 0x3333 -> read = 0x3333.
REQ-037 Scenario: BYPASS=1, REG_OUT=0; write addr 3 = 0xA5A5 while reading addr 3 in the same cycle -> rdata=0xA5A5 that cycle. Repeat with BYPASS=0 -> rdata=0 that cycle and 0xA5A5 the next cycle.
REQ-038 Scenario: REG_OUT=1; raddr=7 changes at cycle N after entry 7 = 0x55 -> rdata=0x55 at cycle N+1 and not before.
REQ-039 Scenario: fill all 64 entries with distinct values, then assert rst at sweep count 20 -> init_busy stays high 64 more cycles; afterwards all entries read 0.
